// File: rtl/xck_pll_sequencer.sv
// XCK PLL bring-up and supervision: reset pulse, lock wait with timeout,
// stability window, bounded retries, then XCK enable and codec reset release.
module xck_pll_sequencer #(
   parameter int unsigned RST_CYCLES   = 64,
   parameter int unsigned LOCK_STABLE  = 1024,
   parameter int unsigned LOCK_TIMEOUT = 50000,
   parameter int unsigned MAX_RETRIES  = 3,
   parameter int unsigned CLK_TO_RST   = 16,
   parameter int unsigned CNT_W        = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       xck_en,
   output logic       audio_rst_n,
   output logic       ready,
   output logic       fault,
   output logic       lock_lost,
   output logic [3:0] retry_cnt,
   output logic [7:0] loss_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PLL_RST,
      S_WAIT_LOCK,
      S_SETTLE,
      S_RUN,
      S_FAULT
   } state_t;

   state_t           state, nxt_state;
   logic [CNT_W-1:0] cnt, nxt_cnt;
   logic [3:0]       nxt_retry;
   logic [7:0]       nxt_loss;
   logic             nxt_lost;
   logic             lk_meta, lk;
   logic             attempt_fail;
   logic [3:0]       retry_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lk_meta <= 1'b0;
         lk      <= 1'b0;
      end else begin
         lk_meta <= pll_locked;
         lk      <= lk_meta;
      end
   end

   assign retry_inc = retry_cnt + 4'd1;

   always_comb begin
      nxt_state    = state;
      nxt_cnt      = cnt;
      nxt_retry    = retry_cnt;
      nxt_loss     = loss_cnt;
      nxt_lost     = 1'b0;
      attempt_fail = 1'b0;

      case (state)
         S_IDLE: begin
            nxt_cnt = '0;
            if (enable) begin
               nxt_state = S_PLL_RST;
               nxt_retry = '0;
            end
         end
         S_PLL_RST: begin
            nxt_cnt = cnt + 1'b1;
            if (cnt == CNT_W'(RST_CYCLES - 1)) begin
               nxt_state = S_WAIT_LOCK;
               nxt_cnt   = '0;
            end
         end
         S_WAIT_LOCK: begin
            nxt_cnt = cnt + 1'b1;
            if (lk) begin
               nxt_state = S_SETTLE;
               nxt_cnt   = '0;
            end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
               attempt_fail = 1'b1;
            end
         end
         S_SETTLE: begin
            nxt_cnt = cnt + 1'b1;
            if (!lk) begin
               attempt_fail = 1'b1;
            end else if (cnt == CNT_W'(LOCK_STABLE - 1)) begin
               nxt_state = S_RUN;
               nxt_cnt   = '0;
            end
         end
         S_RUN: begin
            if (cnt != CNT_W'(CLK_TO_RST)) nxt_cnt = cnt + 1'b1;
            if (!lk) begin
               nxt_lost  = 1'b1;
               nxt_loss  = (loss_cnt == '1) ? loss_cnt : loss_cnt + 8'd1;
               nxt_retry = '0;
               nxt_state = S_PLL_RST;
               nxt_cnt   = '0;
            end
         end
         S_FAULT: begin
            nxt_cnt = '0;
         end
         default: begin
            nxt_state = S_IDLE;
            nxt_cnt   = '0;
         end
      endcase

      if (attempt_fail) begin
         nxt_retry = retry_inc;
         nxt_cnt   = '0;
         nxt_state = (retry_inc == 4'(MAX_RETRIES)) ? S_FAULT : S_PLL_RST;
      end

      // Disable aborts any step but still records a coincident lock loss.
      if (!enable) begin
         nxt_state = S_IDLE;
         nxt_cnt   = '0;
         nxt_retry = retry_cnt;
      end
   end

   // Outputs are registered from the next state so they move with the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         retry_cnt   <= '0;
         loss_cnt    <= '0;
         pll_rst     <= 1'b1;
         xck_en      <= 1'b0;
         audio_rst_n <= 1'b0;
         ready       <= 1'b0;
         fault       <= 1'b0;
         lock_lost   <= 1'b0;
      end else begin
         state       <= nxt_state;
         cnt         <= nxt_cnt;
         retry_cnt   <= nxt_retry;
         loss_cnt    <= nxt_loss;
         pll_rst     <= (nxt_state == S_IDLE) || (nxt_state == S_PLL_RST) ||
                        (nxt_state == S_FAULT);
         xck_en      <= (nxt_state == S_RUN);
         audio_rst_n <= (nxt_state == S_RUN) && (nxt_cnt == CNT_W'(CLK_TO_RST));
         ready       <= (nxt_state == S_RUN) && (nxt_cnt == CNT_W'(CLK_TO_RST));
         fault       <= (nxt_state == S_FAULT);
         lock_lost   <= nxt_lost;
      end
   end

endmodule

// File: tb/tb_xck_pll_sequencer.sv
// Directed bench for xck_pll_sequencer with short timing parameters.
module tb_xck_pll_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       pll_locked;
   logic       pll_rst;
   logic       xck_en;
   logic       audio_rst_n;
   logic       ready;
   logic       fault;
   logic       lock_lost;
   logic [3:0] retry_cnt;
   logic [7:0] loss_cnt;

   int compared   = 0;
   int mismatched = 0;
   int n;

   localparam int SEL_PLL_RST = 0;
   localparam int SEL_XCK_EN  = 1;
   localparam int SEL_READY   = 2;
   localparam int SEL_FAULT   = 3;

   xck_pll_sequencer #(
      .RST_CYCLES  (4),
      .LOCK_STABLE (8),
      .LOCK_TIMEOUT(32),
      .MAX_RETRIES (2),
      .CLK_TO_RST  (3),
      .CNT_W       (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .pll_locked (pll_locked),
      .pll_rst    (pll_rst),
      .xck_en     (xck_en),
      .audio_rst_n(audio_rst_n),
      .ready      (ready),
      .fault      (fault),
      .lock_lost  (lock_lost),
      .retry_cnt  (retry_cnt),
      .loss_cnt   (loss_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic sig_of(input int sel);
      case (sel)
         SEL_PLL_RST: return pll_rst;
         SEL_XCK_EN:  return xck_en;
         SEL_READY:   return ready;
         default:     return fault;
      endcase
   endfunction

   // Cycles until the selected output reaches val; -1 if the budget runs out.
   task automatic run_until(input int sel, input logic val, input int max_cyc, output int cyc);
      cyc = -1;
      for (int i = 1; i <= max_cyc; i++) begin
         tick();
         if (sig_of(sel) === val) begin
            cyc = i;
            break;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; pll_locked = 1'b0;
      repeat (3) tick();
      chk("rst_pll_rst",  32'(pll_rst), 1);
      chk("rst_xck_en",   32'(xck_en), 0);
      chk("rst_audio",    32'(audio_rst_n), 0);
      chk("rst_ready",    32'(ready), 0);
      chk("rst_fault",    32'(fault), 0);
      chk("rst_lost",     32'(lock_lost), 0);
      chk("rst_retry",    32'(retry_cnt), 0);
      chk("rst_loss",     32'(loss_cnt), 0);
      rst_n = 1'b1;
      repeat (2) tick();
      chk("idle_pll_rst", 32'(pll_rst), 1);

      // Clean bring-up
      enable = 1'b1;
      tick();
      chk("up_pll_rst_entry", 32'(pll_rst), 1);
      run_until(SEL_PLL_RST, 1'b0, 20, n);
      chk("up_rst_width", 32'(n), 4);
      repeat (10) tick();
      chk("up_no_xck_before_lock", 32'(xck_en), 0);
      pll_locked = 1'b1;
      run_until(SEL_XCK_EN, 1'b1, 40, n);
      chk("up_lock_to_xck", 32'(n), 11);
      chk("up_audio_low_at_xck", 32'(audio_rst_n), 0);
      run_until(SEL_READY, 1'b1, 20, n);
      chk("up_xck_to_ready", 32'(n), 3);
      chk("up_audio_rst_n", 32'(audio_rst_n), 1);
      chk("up_retry", 32'(retry_cnt), 0);

      // Lock loss in RUN
      repeat (2) tick();
      chk("loss_ready_before", 32'(ready), 1);
      pll_locked = 1'b0;
      run_until(SEL_XCK_EN, 1'b0, 20, n);
      chk("loss_latency", 32'(n), 3);
      chk("loss_pulse", 32'(lock_lost), 1);
      chk("loss_pll_rst", 32'(pll_rst), 1);
      chk("loss_audio", 32'(audio_rst_n), 0);
      chk("loss_ready", 32'(ready), 0);
      chk("loss_cnt_1", 32'(loss_cnt), 1);
      tick();
      chk("loss_pulse_end", 32'(lock_lost), 0);
      run_until(SEL_PLL_RST, 1'b0, 20, n);
      chk("loss_rst_rest", 32'(n), 3);
      pll_locked = 1'b1;
      run_until(SEL_XCK_EN, 1'b1, 40, n);
      chk("loss_rebring_xck", 32'(n), 11);
      run_until(SEL_READY, 1'b1, 20, n);
      chk("loss_rebring_ready", 32'(n), 3);
      chk("loss_cnt_hold", 32'(loss_cnt), 1);

      // Disable from RUN, then timeout followed by success
      enable = 1'b0; pll_locked = 1'b0;
      tick();
      chk("dis_xck", 32'(xck_en), 0);
      chk("dis_ready", 32'(ready), 0);
      chk("dis_pll_rst", 32'(pll_rst), 1);
      chk("dis_no_lost", 32'(lock_lost), 0);
      repeat (3) tick();
      enable = 1'b1;
      tick();
      run_until(SEL_PLL_RST, 1'b0, 20, n);
      chk("to_rst_width1", 32'(n), 4);
      run_until(SEL_PLL_RST, 1'b1, 60, n);
      chk("to_wait_len", 32'(n), 32);
      chk("to_retry", 32'(retry_cnt), 1);
      run_until(SEL_PLL_RST, 1'b0, 20, n);
      chk("to_rst_width2", 32'(n), 4);
      pll_locked = 1'b1;
      run_until(SEL_XCK_EN, 1'b1, 40, n);
      chk("to_run", 32'(n), 11);
      chk("to_retry_run", 32'(retry_cnt), 1);

      // Fault
      enable = 1'b0; pll_locked = 1'b0;
      repeat (3) tick();
      chk("idle_retry_hold", 32'(retry_cnt), 1);
      enable = 1'b1;
      tick();
      chk("f_retry_clear", 32'(retry_cnt), 0);
      run_until(SEL_PLL_RST, 1'b0, 20, n);
      chk("f_rst1", 32'(n), 4);
      run_until(SEL_PLL_RST, 1'b1, 60, n);
      chk("f_wait1", 32'(n), 32);
      run_until(SEL_PLL_RST, 1'b0, 20, n);
      chk("f_rst2", 32'(n), 4);
      run_until(SEL_FAULT, 1'b1, 60, n);
      chk("f_wait2", 32'(n), 32);
      chk("f_retry", 32'(retry_cnt), 2);
      chk("f_pll_rst", 32'(pll_rst), 1);
      repeat (5) tick();
      chk("f_held", 32'(fault), 1);
      chk("f_xck", 32'(xck_en), 0);
      enable = 1'b0;
      tick();
      chk("f_cleared", 32'(fault), 0);
      chk("f_idle_pll_rst", 32'(pll_rst), 1);
      chk("f_idle_retry", 32'(retry_cnt), 2);
      enable = 1'b1;
      tick();
      chk("f_reenable_retry", 32'(retry_cnt), 0);

      // SETTLE drop after 5 cycles of lock
      run_until(SEL_PLL_RST, 1'b0, 20, n);
      chk("sd_rst", 32'(n), 4);
      pll_locked = 1'b1;
      repeat (5) tick();
      pll_locked = 1'b0;
      run_until(SEL_PLL_RST, 1'b1, 20, n);
      chk("sd_fail_latency", 32'(n), 3);
      chk("sd_retry", 32'(retry_cnt), 1);
      chk("sd_no_run", 32'(xck_en), 0);

      // Asynchronous reset during SETTLE
      run_until(SEL_PLL_RST, 1'b0, 20, n);
      chk("ar_rst", 32'(n), 4);
      pll_locked = 1'b1;
      repeat (4) tick();
      rst_n = 1'b0;
      #2;
      chk("ar_pll_rst", 32'(pll_rst), 1);
      chk("ar_retry", 32'(retry_cnt), 0);
      chk("ar_loss", 32'(loss_cnt), 0);
      chk("ar_xck", 32'(xck_en), 0);
      chk("ar_ready", 32'(ready), 0);
      pll_locked = 1'b0;
      tick();
      rst_n = 1'b1;

      // Disable during WAIT_LOCK
      tick();
      chk("ew_entry", 32'(pll_rst), 1);
      run_until(SEL_PLL_RST, 1'b0, 20, n);
      chk("ew_rst", 32'(n), 4);
      repeat (5) tick();
      chk("ew_waiting", 32'(pll_rst), 0);
      enable = 1'b0;
      tick();
      chk("ew_idle_pll_rst", 32'(pll_rst), 1);
      repeat (40) tick();
      chk("ew_idle_stays", 32'(pll_rst), 1);
      chk("ew_retry", 32'(retry_cnt), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
